// File: rtl/ws2811_pkg.sv
// Shared state encoding and default 12.8 MHz timing for the WS2811 strip driver.
package ws2811_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    localparam int DEF_T_CELL       = 16;
    localparam int DEF_T0H          = 4;
    localparam int DEF_T1H          = 12;
    localparam int DEF_RESET_CYCLES = 640;
    localparam logic [2:0] BIT_MSB  = 3'd7;

endpackage

// File: rtl/ws2811_cell_timer.sv
// Bit-cell timing: cycle position inside the current cell and which bit of the byte is on the line.
module ws2811_cell_timer
    import ws2811_pkg::*;
#(
    parameter int T_CELL = DEF_T_CELL,
    parameter int CW     = $clog2(T_CELL)
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          load_i,
    input  logic          run_i,
    output logic [CW-1:0] cell_cnt_nxt_o,
    output logic [2:0]    bit_idx_nxt_o,
    output logic          cell_last_o,
    output logic          byte_last_o
);

    localparam logic [CW-1:0] CNT_LAST = CW'(T_CELL - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;

    assign cell_last_o    = (cnt_q == CNT_LAST);
    // Held for the whole last bit; the byte boundary is cell_last_o & byte_last_o.
    assign byte_last_o    = (bit_q == 3'd0);
    assign cell_cnt_nxt_o = cnt_d;
    assign bit_idx_nxt_o  = bit_d;

    always_comb begin
        cnt_d = '0;
        bit_d = '0;
        if (load_i) begin
            bit_d = BIT_MSB;
        end else if (run_i) begin
            if (cell_last_o) begin
                bit_d = bit_q - 3'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                bit_d = bit_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q <= '0;
            bit_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            bit_q <= bit_d;
        end
    end

endmodule

// File: rtl/ws2811_serializer.sv
// WS2811 line driver: NCH byte lanes serialised MSB-first in lockstep, latch period on underrun.
// Optional frame counter output when WS2811_FRAME_CNT_EN is defined.
module ws2811_serializer
    import ws2811_pkg::*;
#(
    parameter int NCH          = 1,
    parameter int T_CELL       = DEF_T_CELL,
    parameter int T0H          = DEF_T0H,
    parameter int T1H          = DEF_T1H,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [8*NCH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [NCH-1:0]   dout,
    output logic             busy,
    output logic             frame_done
`ifdef WS2811_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int CW = $clog2(T_CELL);
    localparam int LW = $clog2(RESET_CYCLES + 1);
    localparam logic [CW-1:0] T0H_C    = CW'(T0H);
    localparam logic [CW-1:0] T1H_C    = CW'(T1H);
    localparam logic [LW-1:0] LAT_LAST = LW'(RESET_CYCLES - 1);

    if (T0H < 1 || T0H >= T1H || T1H >= T_CELL || RESET_CYCLES < 1) begin : g_bad_params
        $error("ws2811_serializer: illegal timing parameters");
    end

    state_e           state_q;
    logic [8*NCH-1:0] shreg_q;
    logic [LW-1:0]    lat_q;
    logic [NCH-1:0]   dout_q;
    logic             busy_q;
    logic             fd_q;

    logic [CW-1:0] cnt_nxt;
    logic [2:0]    bit_nxt;
    logic          cell_last;
    logic          byte_last;
    logic          byte_end;
    logic          accept;

    // Line level of every lane for a given cycle position and bit of the byte.
    function automatic logic [NCH-1:0] cell_level(input logic [8*NCH-1:0] bytes,
                                                  input logic [CW-1:0]    cnt,
                                                  input logic [2:0]       bidx);
        logic [NCH-1:0] lv;
        lv = '0;
        for (int k = 0; k < NCH; k++) begin
            lv[k] = (cnt < (bytes[8*k + int'(bidx)] ? T1H_C : T0H_C));
        end
        return lv;
    endfunction

    ws2811_cell_timer #(
        .T_CELL (T_CELL),
        .CW     (CW)
    ) u_timer (
        .clk            (clk),
        .rst_           (rst_),
        .load_i         (accept),
        .run_i          (state_q == ST_SHIFT),
        .cell_cnt_nxt_o (cnt_nxt),
        .bit_idx_nxt_o  (bit_nxt),
        .cell_last_o    (cell_last),
        .byte_last_o    (byte_last)
    );

    assign byte_end   = cell_last & byte_last;
    assign s_ready    = (state_q == ST_IDLE) | ((state_q == ST_SHIFT) & byte_end);
    assign accept     = s_valid & s_ready;
    assign dout       = dout_q;
    assign busy       = busy_q;
    assign frame_done = fd_q;

`ifdef WS2811_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    assign frame_cnt = frame_cnt_q;
`endif

    // dout is computed from the timer's next position so the line stays aligned with cell_cnt.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            lat_q   <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            fd_q    <= 1'b0;
`ifdef WS2811_FRAME_CNT_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            fd_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    dout_q <= '0;
                    if (accept) begin
                        state_q <= ST_SHIFT;
                        shreg_q <= s_data;
                        busy_q  <= 1'b1;
                        dout_q  <= cell_level(s_data, cnt_nxt, bit_nxt);
                    end
                end
                ST_SHIFT: begin
                    if (byte_end && accept) begin
                        shreg_q <= s_data;
                        dout_q  <= cell_level(s_data, cnt_nxt, bit_nxt);
                    end else if (byte_end) begin
                        state_q <= ST_LATCH;
                        lat_q   <= '0;
                        dout_q  <= '0;
                        fd_q    <= (LAT_LAST == '0);
                    end else begin
                        dout_q  <= cell_level(shreg_q, cnt_nxt, bit_nxt);
                    end
                end
                ST_LATCH: begin
                    dout_q <= '0;
                    if (lat_q == LAT_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        lat_q   <= '0;
`ifdef WS2811_FRAME_CNT_EN
                        frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
                    end else begin
                        lat_q <= lat_q + 1'b1;
                        fd_q  <= ((lat_q + 1'b1) == LAT_LAST);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    dout_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2811_serializer.sv
// Directed bench for ws2811_serializer: NCH=1 and NCH=3 instances on a shared clock and reset.
module tb_ws2811_serializer;

    localparam int TC = 16;
    localparam int RC = 640;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_;
    logic [7:0]  sd1;
    logic        sv1;
    logic        sr1;
    logic [0:0]  do1;
    logic        bz1;
    logic        fd1;
    logic [23:0] sd3;
    logic        sv3;
    logic        sr3;
    logic [2:0]  do3;
    logic        bz3;
    logic        fd3;
`ifdef WS2811_FRAME_CNT_EN
    logic [15:0] fc1;
    logic [15:0] fc3;
`endif

    ws2811_serializer #(.NCH(1)) u1 (
        .clk        (clk),
        .rst_       (rst_),
        .s_data     (sd1),
        .s_valid    (sv1),
        .s_ready    (sr1),
        .dout       (do1),
        .busy       (bz1),
        .frame_done (fd1)
`ifdef WS2811_FRAME_CNT_EN
        ,
        .frame_cnt  (fc1)
`endif
    );

    ws2811_serializer #(.NCH(3)) u3 (
        .clk        (clk),
        .rst_       (rst_),
        .s_data     (sd3),
        .s_valid    (sv3),
        .s_ready    (sr3),
        .dout       (do3),
        .busy       (bz3),
        .frame_done (fd3)
`ifdef WS2811_FRAME_CNT_EN
        ,
        .frame_cnt  (fc3)
`endif
    );

    typedef struct {
        logic [7:0]  data;
        logic [63:0] hi;   // high cycles per cell, cell 0 (MSB) in [63:56]
    } vec_t;

    vec_t vt[5];
    int checks = 0;
    int errors = 0;
    int nfd1   = 0;

    always @(posedge clk) if (fd1 === 1'b1) nfd1 <= nfd1 + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic accept1(input string tag, input logic [7:0] d, input logic keep);
        sv1 = 1'b1;
        sd1 = d;
        chk({tag, "_acc_ready"}, int'(sr1), 1);
        @(posedge clk);
        @(negedge clk);
        if (!keep) sv1 = 1'b0;
    endtask

    // Entered at the negedge of cycle 0 of the byte; leaves at cycle 0 of what follows.
    task automatic run_byte(input string tag, input logic [63:0] hi,
                            input logic nv, input logic [7:0] nd);
        int mism;
        int rm;
        rm = 0;
        for (int c = 0; c < 8; c++) begin
            mism = 0;
            for (int k = 0; k < TC; k++) begin
                int i;
                int h;
                i = c * TC + k;
                h = int'(hi[8*(7-c) +: 8]);
                if (do1[0] !== (k < h)) mism++;
                if (sr1 !== (i == 8*TC-1)) rm++;
                if (bz1 !== 1'b1) rm++;
                if (i == 8*TC-1) begin
                    sv1 = nv;
                    sd1 = nd;
                end
                @(negedge clk);
            end
            chk($sformatf("%s_cell%0d", tag, c), mism, 0);
        end
        chk({tag, "_ready_busy"}, rm, 0);
    endtask

    task automatic run_latch(input string tag, input int vat, input logic [7:0] vd);
        int bad;
        int nfd;
        int fdpos;
        bad = 0;
        nfd = 0;
        fdpos = -1;
        for (int j = 0; j < RC; j++) begin
            if (do1[0] !== 1'b0 || bz1 !== 1'b1 || sr1 !== 1'b0) bad++;
            if (fd1 === 1'b1) begin
                nfd++;
                fdpos = j;
            end
            if (j == vat) begin
                sv1 = 1'b1;
                sd1 = vd;
            end
            @(negedge clk);
        end
        chk({tag, "_latch_low"}, bad, 0);
        chk({tag, "_fd_count"}, nfd, 1);
        chk({tag, "_fd_pos"}, fdpos, RC-1);
        chk({tag, "_idle_busy"}, int'(bz1), 0);
        chk({tag, "_idle_ready"}, int'(sr1), 1);
        chk({tag, "_idle_fd"}, int'(fd1), 0);
    endtask

    initial begin
        logic [63:0] lh[3];
        int m[3];
        int cyc;
        int bad;

        vt[0] = '{8'hA5, {8'd12, 8'd4, 8'd12, 8'd4, 8'd4, 8'd12, 8'd4, 8'd12}};
        vt[1] = '{8'hFF, {8{8'd12}}};
        vt[2] = '{8'h00, {8{8'd4}}};
        vt[3] = '{8'h81, {8'd12, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd12}};
        vt[4] = '{8'h00, {8{8'd4}}};
        lh[0] = {8'd4, 8'd4, 8'd4, 8'd4, 8'd12, 8'd12, 8'd12, 8'd12};
        lh[1] = {8{8'd12}};
        lh[2] = {8{8'd4}};

        rst_ = 1'b0;
        sv1 = 1'b0; sd1 = '0;
        sv3 = 1'b0; sd3 = '0;
        repeat (3) @(negedge clk);
        chk("rst_dout1", int'(do1), 0);
        chk("rst_busy1", int'(bz1), 0);
        chk("rst_fd1", int'(fd1), 0);
        chk("rst_ready1", int'(sr1), 1);
        chk("rst_dout3", int'(do3), 0);
        chk("rst_ready3", int'(sr3), 1);
        rst_ = 1'b1;
        @(negedge clk);

        // Single byte then underrun
        accept1("t1", vt[0].data, 1'b0);
        run_byte("t1", vt[0].hi, 1'b0, 8'h00);
        run_latch("t1", -1, 8'h00);

        // Back-to-back stream, then s_valid raised during the latch
        accept1("t2", vt[1].data, 1'b1);
        run_byte("t2a", vt[1].hi, 1'b1, vt[2].data);
        run_byte("t2b", vt[2].hi, 1'b1, vt[3].data);
        run_byte("t2c", vt[3].hi, 1'b0, 8'h00);
        run_latch("t4", 100, vt[4].data);
        accept1("t4", vt[4].data, 1'b0);
        run_byte("t4b", vt[4].hi, 1'b0, 8'h00);
        run_latch("t4b", -1, 8'h00);
        chk("frames_seen", nfd1, 3);
`ifdef WS2811_FRAME_CNT_EN
        chk("frame_cnt3", int'(fc1), 3);
`endif

        // Three lanes in lockstep
        sv3 = 1'b1;
        sd3 = 24'h00FF0F;
        chk("t3_acc_ready", int'(sr3), 1);
        @(posedge clk);
        @(negedge clk);
        sv3 = 1'b0;
        m[0] = 0; m[1] = 0; m[2] = 0;
        for (int i = 0; i < 8*TC; i++) begin
            for (int l = 0; l < 3; l++) begin
                if (do3[l] !== ((i % TC) < int'(lh[l][8*(7 - i/TC) +: 8]))) m[l]++;
            end
            @(negedge clk);
        end
        chk("t3_lane0", m[0], 0);
        chk("t3_lane1", m[1], 0);
        chk("t3_lane2", m[2], 0);
        cyc = 0;
        while (fd3 !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("t3_latch_len", cyc, RC-1);
        @(negedge clk);
        chk("t3_idle_busy", int'(bz3), 0);

        // Reset in the middle of bit 4
        accept1("t5", 8'hFF, 1'b0);
        repeat (3*TC + 2) @(negedge clk);
        chk("t5_pre_dout", int'(do1), 1);
        #2 rst_ = 1'b0;
        #1;
        chk("t5_async_dout", int'(do1), 0);
        chk("t5_async_busy", int'(bz1), 0);
        repeat (3) @(negedge clk);
        rst_ = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (do1 !== 1'b0 || bz1 !== 1'b0 || sr1 !== 1'b1 || fd1 !== 1'b0) bad++;
        end
        chk("t5_post_idle", bad, 0);
        chk("t5_no_frame", nfd1, 3);
`ifdef WS2811_FRAME_CNT_EN
        chk("t5_frame_cnt_clr", int'(fc1), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
